// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory address/data, hazard and redirect
// controls in, and the IF/ID pipeline register contents out.
interface instruction_fetch_if;
    logic [31:0] PCAddress;
    logic [31:0] InstrIn;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpTaken;
    logic [31:0] JumpTarget;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Halted;
    logic [31:0] FetchCount;

    // The fetch unit drives the master side; the pipeline and memory sit on the slave side.
    modport master (
        output PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted, FetchCount,
        input  InstrIn, Stall, Flush, BranchTaken, BranchTarget, JumpTaken, JumpTarget
    );
    modport slave (
        input  PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted, FetchCount,
        output InstrIn, Stall, Flush, BranchTaken, BranchTarget, JumpTaken, JumpTarget
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// BOOT/RUN/HALT control FSM with branch/jump redirect, stall and flush.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                Clk,
    input  logic                Reset,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        bubble;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect    = bus.BranchTaken | bus.JumpTaken;
    assign redirect_pc = bus.BranchTaken ? {bus.BranchTarget[31:2], 2'b00}
                                         : {bus.JumpTarget[31:2], 2'b00};

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;
        bubble  = 1'b0;
        unique case (state_q)
            BOOT: begin
                pc_d    = RESET_PC;
                bubble  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d   = redirect_pc;
                    bubble = 1'b1;
                end else if (bus.Stall) begin
                    bubble = bus.Flush;
                end else if (bus.Flush) begin
                    pc_d   = pc_plus4;
                    bubble = 1'b1;
                end else begin
                    instr_d = bus.InstrIn;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                    if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                    // A halt word is kept in IF/ID but the PC stays on it.
                    if (bus.InstrIn == HALT_WORD) state_d = HALT;
                    else                          pc_d    = pc_plus4;
                end
            end
            HALT: begin
                bubble = 1'b1;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        // Bubble contents match the reset image of IF/ID.
        if (bubble) begin
            instr_d = NOP_WORD;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.PCAddress        = pc_q;
    assign bus.IFID_Instruction = instr_q;
    assign bus.IFID_PCPlus4     = pcp4_q;
    assign bus.IFID_Valid       = valid_q;
    assign bus.Halted           = (state_q == HALT);
    assign bus.FetchCount       = count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory word[i] = 3*i, scoreboard
// of expected IF-stage state popped after each rising edge.
module tb_instruction_fetch;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic        halted;
        logic [31:0] count;
    } obs_t;

    typedef struct packed {
        logic        b;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        s;
        logic        f;
    } stim_t;

    logic Clk;
    logic Reset;
    logic halt_en;
    logic [31:0] halt_pc;
    int n_checks;
    int n_fail;

    stim_t stim_q[$];
    obs_t  sb[$];

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (NOP_WORD),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Combinational instruction memory with an optional halt word at halt_pc.
    assign bus.InstrIn = (halt_en && bus.PCAddress == halt_pc) ? HALT_WORD
                                                               : (bus.PCAddress >> 2) * 32'd3;

    function automatic obs_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pcp4, input logic valid,
                                input logic halted, input logic [31:0] count);
        mk = '{pc: pc, instr: instr, pcp4: pcp4, valid: valid, halted: halted, count: count};
    endfunction

    function automatic stim_t st(input logic b, input logic [31:0] bt, input logic j,
                                 input logic [31:0] jt, input logic s, input logic f);
        st = '{b: b, bt: bt, j: j, jt: jt, s: s, f: f};
    endfunction

    function automatic obs_t observe();
        observe = mk(bus.PCAddress, bus.IFID_Instruction, bus.IFID_PCPlus4,
                     bus.IFID_Valid, bus.Halted, bus.FetchCount);
    endfunction

    task automatic push(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        sb.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        bus.BranchTaken  = s.b;
        bus.BranchTarget = s.bt;
        bus.JumpTaken    = s.j;
        bus.JumpTarget   = s.jt;
        bus.Stall        = s.s;
        bus.Flush        = s.f;
    endtask

    task automatic test_reset();
        obs_t e, o;
        stim_t s;
        Reset = 1'b0;
        halt_en = 1'b0;
        halt_pc = 32'h0;
        drive(st(0, 0, 0, 0, 0, 0));
        #3;
        e = mk(32'h0, NOP_WORD, 32'h0, 0, 0, 32'h0);
        o = observe();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_state got %h expected %h", o, e);
        end
        @(posedge Clk); #1;
        Reset = 1'b1;
        #1;
        o = observe();
        n_checks++;
        if (o.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL release_pc got %h expected %h", o.pc, 32'h0);
        end
        push(st(0, 0, 0, 0, 0, 0), mk(32'h0, NOP_WORD, 32'h0, 0, 0, 32'd0));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h4, 32'd0, 32'h4, 1, 0, 32'd1));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h8, 32'd3, 32'h8, 1, 0, 32'd2));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge Clk); #1;
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL boot_fetch got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_stall();
        obs_t e, o;
        stim_t s;
        push(st(0, 0, 0, 0, 0, 0), mk(32'hC, 32'd6, 32'hC, 1, 0, 32'd3));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h10, 32'd9, 32'h10, 1, 0, 32'd4));
        push(st(0, 0, 0, 0, 1, 0), mk(32'h10, 32'd9, 32'h10, 1, 0, 32'd4));
        push(st(0, 0, 0, 0, 1, 0), mk(32'h10, 32'd9, 32'h10, 1, 0, 32'd4));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h14, 32'd12, 32'h14, 1, 0, 32'd5));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge Clk); #1;
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stall got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_flush();
        obs_t e, o;
        stim_t s;
        push(st(0, 0, 0, 0, 1, 1), mk(32'h14, NOP_WORD, 32'h0, 0, 0, 32'd5));
        push(st(0, 0, 0, 0, 0, 1), mk(32'h18, NOP_WORD, 32'h0, 0, 0, 32'd5));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h1C, 32'd18, 32'h1C, 1, 0, 32'd6));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge Clk); #1;
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_redirect();
        obs_t e, o;
        stim_t s;
        push(st(1, 32'h43, 1, 32'h100, 1, 0), mk(32'h40, NOP_WORD, 32'h0, 0, 0, 32'd6));
        push(st(0, 32'h0, 1, 32'h1F, 1, 0), mk(32'h1C, NOP_WORD, 32'h0, 0, 0, 32'd6));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h20, 32'd21, 32'h20, 1, 0, 32'd7));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge Clk); #1;
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL redirect got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_halt();
        obs_t e, o;
        stim_t s;
        halt_pc = 32'h20;
        halt_en = 1'b1;
        push(st(0, 0, 0, 0, 0, 0), mk(32'h20, HALT_WORD, 32'h24, 1, 1, 32'd8));
        push(st(0, 0, 0, 0, 1, 1), mk(32'h20, NOP_WORD, 32'h0, 0, 1, 32'd8));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h20, NOP_WORD, 32'h0, 0, 1, 32'd8));
        push(st(0, 0, 1, 32'h8, 0, 0), mk(32'h8, NOP_WORD, 32'h0, 0, 0, 32'd8));
        push(st(0, 0, 0, 0, 0, 0), mk(32'hC, 32'd6, 32'hC, 1, 0, 32'd9));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge Clk); #1;
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt got %h expected %h", o, e);
            end
        end
        halt_en = 1'b0;
    endtask

    task automatic test_wrap();
        obs_t e, o;
        stim_t s;
        push(st(1, 32'hFFFF_FFFF, 0, 0, 0, 0), mk(32'hFFFF_FFFC, NOP_WORD, 32'h0, 0, 0, 32'd9));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h0, 32'hBFFF_FFFD, 32'h0, 1, 0, 32'd10));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge Clk); #1;
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t e, o;
        stim_t s;
        drive(st(0, 0, 0, 0, 1, 0));
        @(posedge Clk); #1;
        e = mk(32'h0, 32'hBFFF_FFFD, 32'h0, 1, 0, 32'd10);
        o = observe();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL pre_reset_stall got %h expected %h", o, e);
        end
        #2 Reset = 1'b0;
        #1;
        e = mk(32'h0, NOP_WORD, 32'h0, 0, 0, 32'h0);
        o = observe();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_reset got %h expected %h", o, e);
        end
        @(posedge Clk); #1;
        o = observe();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_hold got %h expected %h", o, e);
        end
        drive(st(0, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        push(st(0, 0, 0, 0, 0, 0), mk(32'h0, NOP_WORD, 32'h0, 0, 0, 32'd0));
        push(st(0, 0, 0, 0, 0, 0), mk(32'h4, 32'd0, 32'h4, 1, 0, 32'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge Clk); #1;
            e = sb.pop_front();
            o = observe();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reboot got %h expected %h", o, e);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stall();
        test_flush();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
